// File: rtl/mest_pkg.sv
// rtl/mest_pkg.sv - shared opcodes and sequencer state encoding
package mest_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LOAD_A = 8'h01;
  localparam logic [7:0] OP_ADD    = 8'h02;
  localparam logic [7:0] OP_SUB    = 8'h03;
  localparam logic [7:0] OP_AND    = 8'h04;
  localparam logic [7:0] OP_OR     = 8'h05;
  localparam logic [7:0] OP_XOR    = 8'h06;
  localparam logic [7:0] OP_OUT    = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/mest_prog_mem.sv
// rtl/mest_prog_mem.sv - program storage, synchronous write / asynchronous read
module mest_prog_mem #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [15:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [15:0]              rdata
);

  logic [15:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mest_sequencer.sv
// rtl/mest_sequencer.sv - loads a small instruction program and issues it to the accumulator stage
import mest_pkg::*;

module mest_sequencer #(
  parameter int         DEPTH    = 16,
  parameter logic [7:0] NOP_CODE = OP_NOP
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   LOAD_EN,
  input  logic [7:0]             LOAD_INSTR,
  input  logic [7:0]             LOAD_DATA,
  input  logic                   CLEAR,
  input  logic                   START,
  input  logic                   STALL,
  output logic [7:0]             INSTRUCTION,
  output logic [7:0]             IN_DATA,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [$clog2(DEPTH):0] PROG_LEN,
  output logic                   LOAD_ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  state_e        state_q, state_d;
  logic [LW-1:0] pc_q, pc_d;
  logic [LW-1:0] len_q, len_d;
  logic          err_q, err_d;
  logic [7:0]    instr_q, instr_d;
  logic [7:0]    data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          mem_we;
  logic [15:0]   mem_rdata;

  mest_prog_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (len_q[AW-1:0]),
    .wdata ({LOAD_INSTR, LOAD_DATA}),
    .raddr (pc_q[AW-1:0]),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    err_d   = err_q;
    instr_d = NOP_CODE;
    data_d  = 8'h00;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          pc_d = '0;
          if (LOAD_EN) err_d = 1'b1;
          if (len_q != '0) begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end
        end else if (CLEAR) begin
          len_d = '0;
          err_d = 1'b0;
        end else if (LOAD_EN) begin
          if (len_q == LW'(DEPTH)) begin
            err_d = 1'b1;
          end else begin
            mem_we = 1'b1;
            len_d  = len_q + LW'(1);
          end
        end
      end
      ST_RUN: begin
        if (LOAD_EN) err_d = 1'b1;
        // The full-width counter reaching len_q ends the run, so DEPTH entries never wrap.
        if (pc_q == len_q) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end else if (STALL) begin
          busy_d = 1'b1;
          data_d = data_q;
        end else begin
          busy_d  = 1'b1;
          instr_d = mem_rdata[15:8];
          data_d  = mem_rdata[7:0];
          pc_d    = pc_q + LW'(1);
        end
      end
      ST_FINISH: begin
        if (LOAD_EN) err_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      instr_q <= NOP_CODE;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      err_q   <= err_d;
      instr_q <= instr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign INSTRUCTION = instr_q;
  assign IN_DATA     = data_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign PROG_LEN    = len_q;
  assign LOAD_ERR    = err_q;

endmodule

// File: tb/tb_mest_sequencer.sv
// tb/tb_mest_sequencer.sv - directed bench with a scoreboard of issued program entries
module tb_mest_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       LOAD_EN = 1'b0;
  logic [7:0] LOAD_INSTR = 8'h00;
  logic [7:0] LOAD_DATA = 8'h00;
  logic       CLEAR = 1'b0;
  logic       START = 1'b0;
  logic       STALL = 1'b0;
  logic [7:0] INSTRUCTION;
  logic [7:0] IN_DATA;
  logic       BUSY;
  logic       DONE;
  logic [4:0] PROG_LEN;
  logic       LOAD_ERR;

  mest_sequencer #(.DEPTH(16), .NOP_CODE(8'h00)) dut (
    .CLK(CLK), .RESET(RESET), .LOAD_EN(LOAD_EN), .LOAD_INSTR(LOAD_INSTR),
    .LOAD_DATA(LOAD_DATA), .CLEAR(CLEAR), .START(START), .STALL(STALL),
    .INSTRUCTION(INSTRUCTION), .IN_DATA(IN_DATA), .BUSY(BUSY), .DONE(DONE),
    .PROG_LEN(PROG_LEN), .LOAD_ERR(LOAD_ERR)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  m_instr [16];
  logic [7:0]  m_data [16];
  int          m_len = 0;
  logic        m_err = 1'b0;
  logic [15:0] exp_q [$];
  logic [7:0]  last_out = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [7:0] ins, input logic [7:0] dat);
    LOAD_EN = 1'b1; LOAD_INSTR = ins; LOAD_DATA = dat;
    step();
    LOAD_EN = 1'b0;
    if (m_len == 16) m_err = 1'b1;
    else begin
      m_instr[m_len] = ins; m_data[m_len] = dat; m_len++;
    end
  endtask

  task automatic clear_prog();
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
    m_len = 0; m_err = 1'b0;
  endtask

  task automatic run_prog(input string tag, input int stall_at, input bit load_too);
    logic [7:0] a, acc, out, last_data;
    int done_at, nstall;
    START = 1'b1;
    if (load_too) begin
      LOAD_EN = 1'b1; LOAD_INSTR = 8'h55; LOAD_DATA = 8'h66; m_err = 1'b1;
    end
    step();
    START = 1'b0; LOAD_EN = 1'b0;
    chk({tag, "_busy_start"}, {31'd0, BUSY}, {31'd0, m_len != 0});
    chk({tag, "_err_start"}, {31'd0, LOAD_ERR}, {31'd0, m_err});
    if (m_len == 0) begin
      chk({tag, "_empty_done"}, {31'd0, DONE}, 32'd1);
      chk({tag, "_empty_instr"}, {24'd0, INSTRUCTION}, 32'd0);
      step();
      chk({tag, "_empty_done_drop"}, {30'd0, DONE, BUSY}, 32'd0);
      return;
    end
    for (int i = 0; i < m_len; i++) exp_q.push_back({m_instr[i], m_data[i]});
    a = 0; acc = 0; out = 0; last_data = 0; done_at = -1; nstall = 0;
    for (int c = 0; c < 100; c++) begin
      STALL = (c == stall_at);
      step();
      STALL = 1'b0;
      if (DONE) begin done_at = c; break; end
      if (INSTRUCTION == 8'h00) begin
        nstall++;
        chk({tag, "_stall_hold"}, {24'd0, IN_DATA}, {24'd0, last_data});
      end else if (exp_q.size() == 0) begin
        chk({tag, "_extra_entry"}, {16'd0, INSTRUCTION, IN_DATA}, 32'hFFFF_FFFF);
      end else begin
        chk({tag, "_entry"}, {16'd0, INSTRUCTION, IN_DATA}, {16'd0, exp_q.pop_front()});
        last_data = IN_DATA;
        case (INSTRUCTION)
          8'h01: a = IN_DATA;
          8'h02: acc = acc + a;
          8'h03: acc = acc - a;
          8'h04: acc = acc & a;
          8'h05: acc = acc | a;
          8'h06: acc = acc ^ a;
          8'h07: out = acc;
          default: ;
        endcase
      end
    end
    chk({tag, "_done_cycle"}, done_at, m_len + ((stall_at >= 0) ? 1 : 0));
    chk({tag, "_stall_count"}, nstall, (stall_at >= 0) ? 1 : 0);
    chk({tag, "_left_in_q"}, exp_q.size(), 0);
    chk({tag, "_finish_out"}, {15'd0, BUSY, INSTRUCTION, IN_DATA}, 32'd0);
    exp_q.delete();
    last_out = out;
    step();
    chk({tag, "_done_drop"}, {30'd0, DONE, BUSY}, 32'd0);
  endtask

  initial begin
    logic seen_done;
    step(); step();
    chk("reset_out", {14'd0, INSTRUCTION, IN_DATA, BUSY, DONE}, 32'd0);
    chk("reset_len", {26'd0, PROG_LEN, LOAD_ERR}, 32'd0);
    RESET = 1'b0;
    step();

    load(8'h01, 8'h05); load(8'h02, 8'h00); load(8'h02, 8'h00); load(8'h07, 8'h00);
    chk("basic_len", {27'd0, PROG_LEN}, m_len);
    run_prog("basic", -1, 1'b0);
    chk("basic_out_data", {24'd0, last_out}, 32'h0A);
    run_prog("rerun", -1, 1'b0);
    chk("rerun_out_data", {24'd0, last_out}, 32'h0A);
    chk("rerun_len", {27'd0, PROG_LEN}, 32'd4);

    clear_prog();
    load(8'h01, 8'h03); load(8'h02, 8'h04); load(8'h07, 8'h09);
    run_prog("stall", 1, 1'b0);

    clear_prog();
    chk("clear_len", {27'd0, PROG_LEN}, 32'd0);
    run_prog("empty", -1, 1'b0);

    clear_prog();
    for (int i = 0; i < 17; i++) load(8'((i % 7) + 1), 8'(i * 3));
    chk("full_len", {27'd0, PROG_LEN}, 32'd16);
    chk("full_err", {31'd0, LOAD_ERR}, 32'd1);
    run_prog("full", -1, 1'b0);

    clear_prog();
    chk("clear_err", {31'd0, LOAD_ERR}, 32'd0);
    load(8'h01, 8'h11); load(8'h06, 8'h22);
    run_prog("start_load", -1, 1'b1);
    chk("start_load_len", {27'd0, PROG_LEN}, 32'd2);
    chk("start_load_err", {31'd0, LOAD_ERR}, 32'd1);
    CLEAR = 1'b1; LOAD_EN = 1'b1; LOAD_INSTR = 8'h03; LOAD_DATA = 8'h44;
    step();
    CLEAR = 1'b0; LOAD_EN = 1'b0; m_len = 0; m_err = 1'b0;
    chk("clear_load_len", {27'd0, PROG_LEN}, 32'd0);
    chk("clear_load_err", {31'd0, LOAD_ERR}, 32'd0);

    load(8'h01, 8'h01); load(8'h02, 8'h02); load(8'h03, 8'h03); load(8'h07, 8'h04);
    START = 1'b1;
    step();
    START = 1'b0;
    step(); step(); step();
    chk("pre_reset_entry2", {16'd0, INSTRUCTION, IN_DATA}, 32'h0303);
    #2;
    RESET = 1'b1;
    #1;
    chk("mid_reset_out", {14'd0, INSTRUCTION, IN_DATA, BUSY, DONE}, 32'd0);
    chk("mid_reset_len", {26'd0, PROG_LEN, LOAD_ERR}, 32'd0);
    step();
    RESET = 1'b0;
    m_len = 0; m_err = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      seen_done = seen_done | DONE | BUSY;
    end
    chk("post_reset_no_done", {31'd0, seen_done}, 32'd0);
    chk("post_reset_out", {16'd0, INSTRUCTION, IN_DATA}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mest_sequencer.md
MEST_SEQUENCER -- requirements
Module: mest_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of program entries (power of two, 2..256).
REQ-002 SHALL have parameter NOP_CODE, default 8'h00, meaning the instruction value driven when no entry is being issued.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port LOAD_EN  input  1  writes one program entry per cycle while high.
REQ-006 SHALL have port LOAD_INSTR  input  8  opcode of the entry being loaded.
REQ-007 SHALL have port LOAD_DATA  input  8  operand of the entry being loaded.
REQ-008 SHALL have port CLEAR  input  1  empties the program (write pointer to 0).
REQ-009 SHALL have port START  input  1  begins issuing the stored program.
REQ-010 SHALL have port STALL  input  1  freezes issue for the cycle.
REQ-011 SHALL have port INSTRUCTION  output  8  registered opcode to the downstream accumulator stage.
REQ-012 SHALL have port IN_DATA  output  8  registered operand to the downstream stage.
REQ-013 SHALL have port BUSY  output  1  high in state RUN.
REQ-014 SHALL have port DONE  output  1  one-cycle pulse when a run completes.
REQ-015 SHALL have port PROG_LEN  output  $clog2(DEPTH)+1  number of stored entries.
REQ-016 SHALL have port LOAD_ERR  output  1  sticky flag for a rejected load.

Function
REQ-017 SHALL implement states IDLE, RUN, FINISH; IDLE->RUN on START with PROG_LEN>0; IDLE->FINISH on START with PROG_LEN=0; RUN->FINISH after the last entry issues; FINISH->IDLE unconditionally.
REQ-018 SHALL, in IDLE, store {LOAD_INSTR, LOAD_DATA} at the write pointer and increment PROG_LEN on each LOAD_EN cycle.
REQ-019 SHALL ignore LOAD_EN when PROG_LEN=DEPTH, leaving contents unchanged and setting LOAD_ERR.
REQ-020 SHALL ignore LOAD_EN in RUN or FINISH and set LOAD_ERR.
REQ-021 SHALL, on CLEAR in IDLE, set PROG_LEN to 0 and clear LOAD_ERR; CLEAR outside IDLE is ignored; CLEAR wins over a simultaneous LOAD_EN.
REQ-022 SHALL give START priority over a simultaneous LOAD_EN/CLEAR; those are ignored, with LOAD_ERR set for the LOAD_EN.
REQ-023 SHALL ignore START outside IDLE.
REQ-024 SHALL have latency: START sampled at edge k gives entry 0 on INSTRUCTION/IN_DATA after edge k+1; entry n follows one cycle later per unstalled cycle.
REQ-025 SHALL, on a RUN cycle with STALL high, drive INSTRUCTION=NOP_CODE, hold IN_DATA and not advance the program counter.
REQ-026 SHALL drive INSTRUCTION=NOP_CODE and IN_DATA=0 in IDLE and FINISH.
REQ-027 SHALL assert DONE only during the single FINISH cycle.
REQ-028 SHALL preserve program contents and PROG_LEN after a run, so a later START reissues the same program.
REQ-029 SHALL keep the program counter at width $clog2(DEPTH)+1 so PROG_LEN=DEPTH terminates without wrap-around.

Reset
REQ-030 SHALL, while RESET is high, force state IDLE, program counter 0, PROG_LEN 0, LOAD_ERR 0, BUSY 0, DONE 0, INSTRUCTION=NOP_CODE, IN_DATA=0.
REQ-031 SHALL abort an in-progress run on RESET with no DONE pulse; memory contents need not be reset.

Structure
REQ-032 SHALL take from a shared package mest_pkg: opcode constants (NOP=0, LOAD_A=1, ADD=2, SUB=3, AND=4, OR=5, XOR=6, OUT=7) and the state enumeration.
REQ-033 SHALL place program storage in one sub-module mest_prog_mem (DEPTH x 16-bit, synchronous write, asynchronous read).

Verification
REQ-034 SHALL test a load/run: load {1,0x05},{2,0},{2,0},{7,0}, START -> outputs 1/05, 2, 2, 7 in consecutive cycles, then DONE one cycle, downstream OUT_DATA=0x0A.
REQ-035 SHALL test full memory: load 17 entries with DEPTH=16 -> PROG_LEN=16, LOAD_ERR=1, run issues exactly 16 entries.
REQ-036 SHALL test STALL: 3-entry program with STALL high on 2nd RUN cycle -> INSTRUCTION=NOP that cycle, entry 1 issued next cycle, run lasts 4 cycles.
REQ-037 SHALL test empty start: START with PROG_LEN=0 -> BUSY stays 0, DONE pulses after next edge.
REQ-038 SHALL test reset mid-run: RESET during entry 2 of 4 -> outputs NOP/0 immediately, no DONE, PROG_LEN=0.
REQ-039 SHALL test simultaneous events: START+LOAD_EN in IDLE -> run begins, entry not stored, LOAD_ERR=1; CLEAR+LOAD_EN -> PROG_LEN=0.
